rs_aged: RTL and testbench
==========================

RS_AGED -- requirements
Module: rs_aged

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, RS depth (power of 2, >= ALLOC_W).
REQ-002 SHALL have parameter ALLOC_W, default 2, instructions allocated per cycle.
REQ-003 SHALL have parameter NUM_LANES, default 4, dispatch lanes / CDB lanes.
REQ-004 SHALL have parameters NUM_SRCS, default 2; DATA_W, default 32; TAG_W, default 6 (robid width).
REQ-005 SHALL have ports clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have alloc_v in ALLOC_W, per-slot allocate request; alloc_rdy out 1, RS accepts the whole group.
REQ-007 SHALL have alloc_robid in ALLOC_W x TAG_W; alloc_lane_mask in ALLOC_W x NUM_LANES, legal lanes.
REQ-008 SHALL have alloc_src_rdy in ALLOC_W x NUM_SRCS; alloc_src_tag in ALLOC_W x NUM_SRCS x TAG_W; alloc_src_data in ALLOC_W x NUM_SRCS x DATA_W.
REQ-009 SHALL have cdb_v in NUM_LANES; cdb_robid in NUM_LANES x TAG_W; cdb_data in NUM_LANES x DATA_W.
REQ-010 SHALL have lane_free in NUM_LANES, FU accepts an instruction next cycle.
REQ-011 SHALL have disp_v out NUM_LANES; disp_robid out NUM_LANES x TAG_W; disp_src out NUM_LANES x NUM_SRCS x DATA_W.
REQ-012 SHALL have flush in 1, discard all entries; occupancy out clog2(NUM_ENTRIES)+1.

Function
REQ-013 SHALL assert alloc_rdy iff free entries >= ALLOC_W and flush is low; allocation occurs only for slots with alloc_v & alloc_rdy, no partial group.
REQ-014 SHALL place slot i in the i-th lowest free entry; lower slot is older than higher slot.
REQ-015 SHALL keep an NUM_ENTRIES x NUM_ENTRIES age matrix; a new entry becomes younger than all valid entries and all lower allocation slots of the same cycle.
REQ-016 SHALL, for each valid entry source with pending tag matching any cdb_v lane robid, capture cdb_data and mark the source ready at the next edge; if several lanes match, the lowest lane wins.
REQ-017 SHALL treat an entry as ready when valid and all sources ready; ready state is taken from registered entry state (no same-cycle CDB-to-dispatch path).
REQ-018 SHALL, per lane L with lane_free[L], select the oldest ready entry with lane_mask[L] not already chosen by a lane < L.
REQ-019 SHALL register the dispatch: disp_v/disp_robid/disp_src valid the cycle after selection; the selected entry is invalidated at that same edge.
REQ-020 SHALL make disp_v[L] 0 when lane_free[L] is low or no candidate exists.
REQ-021 SHALL let an entry be freed and reallocated in the same cycle only by allocation at the following edge (freed entries are counted free from the next cycle).
REQ-022 SHALL, on flush, clear all valid bits and disp_v at the next edge; alloc and dispatch in the flush cycle are suppressed.
REQ-023 SHALL drive occupancy as the registered valid-entry count, range 0..NUM_ENTRIES.

Reset
REQ-024 SHALL, on rst asserted, asynchronously clear all valid bits, the age matrix, disp_v, and occupancy; alloc_rdy is 0 during reset and 1 in the first cycle after release.
REQ-025 SHALL leave payload registers (data, tags, disp_src, disp_robid) unreset.

Configuration
REQ-026 SHALL honour macro RS_AGED_ALLOC_BYPASS_EN: defined -> an allocating non-ready source whose tag matches a same-cycle CDB lane is written ready with cdb_data; undefined -> it stays pending and waits for a later broadcast (producer must not complete before allocation).

Structure
REQ-027 SHALL take TAG_W, DATA_W, and the rs entry struct from the shared structs/constants package.
REQ-028 SHALL implement oldest-ready selection in a sub-module rs_age_pick (age matrix plus request vector in, one-hot grant out), instantiated once per lane.

Verification
REQ-029 SHALL cover: two ready ALU entries, robid 3 allocated before robid 7, one lane free -> disp_robid 3 first, 7 the next cycle.
REQ-030 SHALL cover: entry with src tag 5 pending, cdb_v lane 2 robid 5 data 0xDEAD -> dispatch one cycle later with disp_src 0xDEAD.
REQ-031 SHALL cover: fill to NUM_ENTRIES-1 with ALLOC_W=2 -> alloc_rdy 0, no entry written; one dispatch -> alloc_rdy 1.
REQ-032 SHALL cover: one ready entry legal on lanes 0 and 1, both free -> only disp_v[0] 1.
REQ-033 SHALL cover: flush with 10 valid entries -> occupancy 0 and disp_v 0 next cycle.
REQ-034 SHALL cover: alloc source tag 9 with CDB robid 9 in the same cycle -> dispatch after 1 cycle with macro defined, never dispatches without it.

Source files
------------

// File: rtl/rs_aged_pkg.sv
// rtl/rs_aged_pkg.sv - shared widths and entry layout for the aged reservation station
package rs_aged_pkg;

    localparam int RS_TAG_W     = 6;
    localparam int RS_DATA_W    = 32;
    localparam int RS_NUM_SRCS  = 2;
    localparam int RS_NUM_LANES = 4;

    typedef struct packed {
        logic [RS_TAG_W-1:0]                       robid;
        logic [RS_NUM_LANES-1:0]                   lane_mask;
        logic [RS_NUM_SRCS-1:0]                    src_rdy;
        logic [RS_NUM_SRCS-1:0][RS_TAG_W-1:0]      src_tag;
        logic [RS_NUM_SRCS-1:0][RS_DATA_W-1:0]     src_data;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_pick.sv
// rtl/rs_age_pick.sv - one-hot grant of the oldest requester from an age matrix
module rs_age_pick
    import rs_aged_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        gnt_o
);

    // age_i[j][i] set means entry j is older than entry i
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = req_i[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && req_i[j] && age_i[j][i]) begin
                    gnt_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rs_aged.sv
// rtl/rs_aged.sv - age-ordered reservation station; RS_AGED_ALLOC_BYPASS_EN enables CDB capture at allocation
module rs_aged
    import rs_aged_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int ALLOC_W     = 2,
    parameter int NUM_LANES   = RS_NUM_LANES,
    parameter int NUM_SRCS    = RS_NUM_SRCS,
    parameter int DATA_W      = RS_DATA_W,
    parameter int TAG_W       = RS_TAG_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ALLOC_W-1:0]                            alloc_v,
    output logic                                          alloc_rdy,
    input  logic [ALLOC_W-1:0][TAG_W-1:0]                 alloc_robid,
    input  logic [ALLOC_W-1:0][NUM_LANES-1:0]             alloc_lane_mask,
    input  logic [ALLOC_W-1:0][NUM_SRCS-1:0]              alloc_src_rdy,
    input  logic [ALLOC_W-1:0][NUM_SRCS-1:0][TAG_W-1:0]   alloc_src_tag,
    input  logic [ALLOC_W-1:0][NUM_SRCS-1:0][DATA_W-1:0]  alloc_src_data,
    input  logic [NUM_LANES-1:0]                          cdb_v,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]               cdb_robid,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]              cdb_data,
    input  logic [NUM_LANES-1:0]                          lane_free,
    output logic [NUM_LANES-1:0]                          disp_v,
    output logic [NUM_LANES-1:0][TAG_W-1:0]               disp_robid,
    output logic [NUM_LANES-1:0][NUM_SRCS-1:0][DATA_W-1:0] disp_src,
    input  logic                                          flush,
    output logic [$clog2(NUM_ENTRIES):0]                  occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0]                   valid_q, valid_d;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]  age_q, age_d;
    rs_entry_t                                ent_q [NUM_ENTRIES];
    rs_entry_t                                ent_d [NUM_ENTRIES];
    logic [OCC_W-1:0]                         occ_q, occ_d;
    logic [NUM_LANES-1:0]                     disp_v_q, disp_v_d;
    logic [NUM_LANES-1:0][TAG_W-1:0]          disp_robid_q, disp_robid_d;
    logic [NUM_LANES-1:0][NUM_SRCS-1:0][DATA_W-1:0] disp_src_q, disp_src_d;

    logic [NUM_ENTRIES-1:0] ready;
    logic [NUM_ENTRIES-1:0] gnt   [NUM_LANES];
    logic [NUM_ENTRIES-1:0] taken [NUM_LANES];
    logic [NUM_ENTRIES-1:0] gnt_any;
    logic [NUM_ENTRIES-1:0] free_m, older_new;
    logic [IDX_W-1:0]       slot_idx;
    logic                   found;

    assign alloc_rdy = !rst && !flush && ((OCC_W'(NUM_ENTRIES) - occ_q) >= OCC_W'(ALLOC_W));

    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            ready[e] = valid_q[e] && (&ent_q[e].src_rdy);
        end
    end

    // Lanes pick in ascending order; an entry taken by a lower lane is masked for higher ones
    assign taken[0] = '0;
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [NUM_ENTRIES-1:0] req;
        always_comb begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                req[e] = lane_free[l] && ready[e] && ent_q[e].lane_mask[l] && !taken[l][e];
            end
        end
        rs_age_pick #(.N(NUM_ENTRIES)) u_pick (
            .req_i (req),
            .age_i (age_q),
            .gnt_o (gnt[l])
        );
        if (l < NUM_LANES - 1) begin : g_chain
            assign taken[l+1] = taken[l] | gnt[l];
        end
    end

    always_comb begin
        disp_v_d     = '0;
        disp_robid_d = '0;
        disp_src_d   = '0;
        gnt_any      = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            gnt_any = gnt_any | gnt[l];
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (gnt[l][e]) begin
                    disp_v_d[l]     = !flush;
                    disp_robid_d[l] = ent_q[e].robid;
                    disp_src_d[l]   = ent_q[e].src_data;
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q & ~gnt_any;
        age_d     = age_q;
        free_m    = ~valid_q;
        older_new = '0;
        slot_idx  = '0;
        found     = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            ent_d[e] = ent_q[e];
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (valid_q[e] && !ent_q[e].src_rdy[s]) begin
                    for (int l = NUM_LANES - 1; l >= 0; l--) begin
                        if (cdb_v[l] && cdb_robid[l] == ent_q[e].src_tag[s]) begin
                            ent_d[e].src_rdy[s]  = 1'b1;
                            ent_d[e].src_data[s] = cdb_data[l];
                        end
                    end
                end
            end
        end
        for (int a = 0; a < ALLOC_W; a++) begin
            slot_idx = '0;
            found    = 1'b0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (free_m[e] && !found) begin
                    slot_idx = IDX_W'(e);
                    found    = 1'b1;
                end
            end
            free_m[slot_idx] = 1'b0;
            if (alloc_v[a] && alloc_rdy) begin
                valid_d[slot_idx]           = 1'b1;
                ent_d[slot_idx].robid       = alloc_robid[a];
                ent_d[slot_idx].lane_mask   = alloc_lane_mask[a];
                ent_d[slot_idx].src_rdy     = alloc_src_rdy[a];
                ent_d[slot_idx].src_tag     = alloc_src_tag[a];
                ent_d[slot_idx].src_data    = alloc_src_data[a];
`ifdef RS_AGED_ALLOC_BYPASS_EN
                for (int s = 0; s < NUM_SRCS; s++) begin
                    if (!alloc_src_rdy[a][s]) begin
                        for (int l = NUM_LANES - 1; l >= 0; l--) begin
                            if (cdb_v[l] && cdb_robid[l] == alloc_src_tag[a][s]) begin
                                ent_d[slot_idx].src_rdy[s]  = 1'b1;
                                ent_d[slot_idx].src_data[s] = cdb_data[l];
                            end
                        end
                    end
                end
`endif
                // Youngest: clear its row, mark every resident and earlier slot as older
                age_d[slot_idx] = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    age_d[j][slot_idx] = valid_q[j] || older_new[j];
                end
                older_new[slot_idx] = 1'b1;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
        occ_d = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            occ_d = occ_d + OCC_W'(valid_d[e]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            age_q    <= '0;
            disp_v_q <= '0;
            occ_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            age_q    <= age_d;
            disp_v_q <= disp_v_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q        <= ent_d;
        disp_robid_q <= disp_robid_d;
        disp_src_q   <= disp_src_d;
    end

    assign disp_v     = disp_v_q;
    assign disp_robid = disp_robid_q;
    assign disp_src   = disp_src_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_rs_aged.sv
// tb/tb_rs_aged.sv - scoreboard bench for rs_aged with directed vectors
module tb_rs_aged;
    import rs_aged_pkg::*;

    localparam int NE = 16, AW = 2, NL = 4, NS = 2, DW = 32, TW = 6;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0]                     alloc_v;
    logic                              alloc_rdy;
    logic [AW-1:0][TW-1:0]             alloc_robid;
    logic [AW-1:0][NL-1:0]             alloc_lane_mask;
    logic [AW-1:0][NS-1:0]             alloc_src_rdy;
    logic [AW-1:0][NS-1:0][TW-1:0]     alloc_src_tag;
    logic [AW-1:0][NS-1:0][DW-1:0]     alloc_src_data;
    logic [NL-1:0]                     cdb_v;
    logic [NL-1:0][TW-1:0]             cdb_robid;
    logic [NL-1:0][DW-1:0]             cdb_data;
    logic [NL-1:0]                     lane_free;
    logic [NL-1:0]                     disp_v;
    logic [NL-1:0][TW-1:0]             disp_robid;
    logic [NL-1:0][NS-1:0][DW-1:0]     disp_src;
    logic                              flush;
    logic [4:0]                        occupancy;

    rs_aged #(.NUM_ENTRIES(NE), .ALLOC_W(AW), .NUM_LANES(NL),
              .NUM_SRCS(NS), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_v         (alloc_v),
        .alloc_rdy       (alloc_rdy),
        .alloc_robid     (alloc_robid),
        .alloc_lane_mask (alloc_lane_mask),
        .alloc_src_rdy   (alloc_src_rdy),
        .alloc_src_tag   (alloc_src_tag),
        .alloc_src_data  (alloc_src_data),
        .cdb_v           (cdb_v),
        .cdb_robid       (cdb_robid),
        .cdb_data        (cdb_data),
        .lane_free       (lane_free),
        .disp_v          (disp_v),
        .disp_robid      (disp_robid),
        .disp_src        (disp_src),
        .flush           (flush),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            lane;
        logic [TW-1:0] robid;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] dat(int r, int s);
        return 32'hA000_0000 | DW'(r << 8) | DW'(s);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(int s, int robid, logic [NL-1:0] mask, logic [NS-1:0] rdy, int tag0);
        alloc_v[s]           = 1'b1;
        alloc_robid[s]       = TW'(robid);
        alloc_lane_mask[s]   = mask;
        alloc_src_rdy[s]     = rdy;
        alloc_src_tag[s][0]  = TW'(tag0);
        alloc_src_tag[s][1]  = '0;
        alloc_src_data[s][0] = dat(robid, 0);
        alloc_src_data[s][1] = dat(robid, 1);
    endtask

    task automatic push(int lane, int robid, logic [DW-1:0] s0, int c);
        exp_t e;
        e.lane  = lane;
        e.robid = TW'(robid);
        e.s0    = s0;
        e.s1    = dat(robid, 1);
        e.cyc   = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NL; l++) begin
                if (disp_v[l]) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_dispatch lane %0d robid %0d: got disp_v 1 expected 0 (cycle %0d)",
                                 l, disp_robid[l], cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("disp_lane", 64'(l), 64'(mon_e.lane));
                        chk("disp_robid", 64'(disp_robid[l]), 64'(mon_e.robid));
                        chk("disp_src0", 64'(disp_src[l][0]), 64'(mon_e.s0));
                        chk("disp_src1", 64'(disp_src[l][1]), 64'(mon_e.s1));
                        chk("disp_cycle", 64'(cyc), 64'(mon_e.cyc));
                    end
                end
            end
        end
    end

    int m;

    initial begin
        rst = 1'b1;
        alloc_v = '0; alloc_robid = '0; alloc_lane_mask = '0; alloc_src_rdy = '0;
        alloc_src_tag = '0; alloc_src_data = '0;
        cdb_v = '0; cdb_robid = '0; cdb_data = '0;
        lane_free = '0; flush = 1'b0;

        #7;
        chk("reset_alloc_rdy", 64'(alloc_rdy), 64'd0);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_disp_v", 64'(disp_v), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("alloc_rdy_after_reset", 64'(alloc_rdy), 64'd1);
        tick();

        // robid 3 allocated before robid 7, single ALU lane
        set_slot(0, 3, 4'b0001, 2'b11, 0);
        tick();
        set_slot(0, 7, 4'b0001, 2'b11, 0);
        tick();
        alloc_v = '0;
        chk("occ_two", 64'(occupancy), 64'd2);
        m = cyc;
        lane_free = 4'b0001;
        push(0, 3, dat(3, 0), m + 1);
        push(0, 7, dat(7, 0), m + 2);
        tick(); tick(); tick();
        lane_free = '0;

        // pending source woken by CDB; lanes 2 and 3 both match, lane 2 wins
        lane_free = 4'b0001;
        set_slot(0, 10, 4'b0001, 2'b10, 5);
        tick();
        alloc_v = '0;
        cdb_v = 4'b1101;
        cdb_robid[0] = 6'd6; cdb_data[0] = 32'h1111;
        cdb_robid[2] = 6'd5; cdb_data[2] = 32'hDEAD;
        cdb_robid[3] = 6'd5; cdb_data[3] = 32'hBEEF;
        push(0, 10, 32'hDEAD, cyc + 2);
        tick();
        cdb_v = '0;
        tick(); tick();
        lane_free = '0;
        chk("occ_after_wakeup", 64'(occupancy), 64'd0);

        // fill to NUM_ENTRIES-1, then a full group must be refused
        for (int i = 0; i < 7; i++) begin
            set_slot(0, 20 + 2 * i, 4'b0010, 2'b11, 0);
            set_slot(1, 21 + 2 * i, 4'b0010, 2'b11, 0);
            tick();
        end
        alloc_v = '0;
        set_slot(0, 34, 4'b0010, 2'b11, 0);
        tick();
        alloc_v = '0;
        chk("occ_fifteen", 64'(occupancy), 64'd15);
        chk("alloc_rdy_near_full", 64'(alloc_rdy), 64'd0);
        set_slot(0, 60, 4'b0010, 2'b11, 0);
        set_slot(1, 61, 4'b0010, 2'b11, 0);
        tick();
        alloc_v = '0;
        chk("occ_refused_group", 64'(occupancy), 64'd15);
        m = cyc;
        lane_free = 4'b0010;
        for (int k = 0; k < 5; k++) push(1, 20 + k, dat(20 + k, 0), m + 1 + k);
        tick();
        chk("alloc_rdy_after_one_disp", 64'(alloc_rdy), 64'd1);
        chk("occ_fourteen", 64'(occupancy), 64'd14);
        tick(); tick(); tick(); tick();
        lane_free = '0;
        chk("occ_ten", 64'(occupancy), 64'd10);

        // flush with 10 valid entries, alloc and dispatch attempted in the same cycle
        flush = 1'b1;
        lane_free = 4'b0010;
        set_slot(0, 62, 4'b0010, 2'b11, 0);
        #1;
        chk("alloc_rdy_in_flush", 64'(alloc_rdy), 64'd0);
        tick();
        flush = 1'b0;
        lane_free = '0;
        alloc_v = '0;
        chk("occ_after_flush", 64'(occupancy), 64'd0);
        chk("disp_v_after_flush", 64'(disp_v), 64'd0);
        tick();

        // one entry legal on lanes 0 and 1, both free: only lane 0 dispatches
        lane_free = 4'b0011;
        m = cyc;
        set_slot(0, 40, 4'b0011, 2'b11, 0);
        push(0, 40, dat(40, 0), m + 2);
        tick();
        alloc_v = '0;
        tick(); tick(); tick();
        lane_free = '0;
        chk("occ_after_dual_lane", 64'(occupancy), 64'd0);

        // source tag 9 broadcast in the allocation cycle
        lane_free = 4'b0001;
        m = cyc;
        set_slot(0, 50, 4'b0001, 2'b10, 9);
        cdb_v = 4'b0001;
        cdb_robid[0] = 6'd9;
        cdb_data[0] = 32'h9999;
`ifdef RS_AGED_ALLOC_BYPASS_EN
        push(0, 50, 32'h9999, m + 2);
`endif
        tick();
        alloc_v = '0;
        cdb_v = '0;
        tick(); tick(); tick(); tick();
`ifdef RS_AGED_ALLOC_BYPASS_EN
        chk("occ_bypass", 64'(occupancy), 64'd0);
`else
        chk("occ_no_bypass", 64'(occupancy), 64'd1);
`endif
        lane_free = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
